sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter W, default 8: data width in bits, legal range 1..64.
REQ-002 SHALL have parameter LOGD, default 7: log2 of depth; depth D = 2^LOGD entries, legal range 1..12.
REQ-003 SHALL have parameter AF_THRESH, default D-2: almost-full threshold in entries, legal range 1..D.
REQ-004 SHALL have parameter AE_THRESH, default 2: almost-empty threshold in entries, legal range 0..D-1.
REQ-005 SHALL have a single clock and a synchronous, active-high reset, named clk and i_rst.
REQ-006 SHALL have these ports, one per line: name, direction, width, meaning.
  clk  in  1  clock; all state changes on its rising edge
  i_rst  in  1  synchronous active-high reset
  i_wr  in  1  write request
  i_data  in  W  write data
  i_rd  in  1  read request; pops the entry currently shown on o_data
  o_data  out  W  head-of-queue data (first-word-fall-through)
  o_full  out  1  D entries held
  o_empty  out  1  0 entries held
  o_afull  out  1  count >= AF_THRESH
  o_aempty  out  1  count <= AE_THRESH
  o_count  out  LOGD+1  entries held, 0..D
  o_overflow  out  1  sticky: write attempted while full and not accepted
  o_underflow  out  1  sticky: read attempted while empty

Function
REQ-007 SHALL store all D entries; pointers are LOGD+1 bits, with full = MSBs differ and LSBs equal, and empty = pointers equal.
REQ-008 SHALL accept a read (rd_ok) iff i_rd && !o_empty; a simultaneous write to an empty FIFO SHALL NOT make that read succeed.
REQ-009 SHALL accept a write (wr_ok) iff i_wr && (!o_full || rd_ok); a write to a full FIFO with a concurrent accepted read SHALL succeed.
REQ-010 SHALL drive o_data = mem[rd_ptr] combinationally; a written word SHALL appear on o_data the cycle after its write edge when the FIFO was empty.
REQ-011 SHALL update o_count by +1 for wr_ok only, -1 for rd_ok only, and 0 for both or neither; o_count SHALL never exceed D or go below 0.
REQ-012 SHALL register o_full, o_empty, o_afull and o_aempty from the next-state count, so that they change on the same edge as o_count.
REQ-013 SHALL wrap pointers modulo 2^(LOGD+1) with no gap or skipped entry at wrap.
REQ-014 SHALL preserve data order exactly (FIFO) across any mix of simultaneous operations.
REQ-015 SHALL leave memory contents unchanged on rejected writes; a rejected read SHALL leave the pointers unchanged.

Reset
REQ-016 On i_rst=1 at a clk edge, SHALL set pointers=0, o_count=0, o_empty=1, o_full=0, o_aempty=1, o_afull=(AF_THRESH==0 ? 1 : 0), o_overflow=0, o_underflow=0.
REQ-017 SHALL give reset priority over concurrent i_wr/i_rd; requests in the reset cycle SHALL be discarded.
REQ-018 SHALL NOT reset the memory array; o_data SHALL be undefined while o_empty=1.

Configuration
REQ-019 With macro SYNC_FIFO_ERR_EN defined, o_overflow SHALL set on (i_wr && !wr_ok) and o_underflow SHALL set on (i_rd && !rd_ok); both SHALL clear only on i_rst.
REQ-020 Without SYNC_FIFO_ERR_EN, o_overflow and o_underflow SHALL be tied to 0 and no flag registers SHALL be synthesised; all other behaviour is identical.

Structure
REQ-021 SHALL place the pointer-width/depth derivation constants and the parameter legality checks in shared package sync_fifo_pkg.
REQ-022 SHALL implement storage as sub-module sync_fifo_ram (1 write port, 1 asynchronous read port, parameters W and LOGD); pointer, count and flag logic SHALL reside in sync_fifo.

Verification (W=8, LOGD=3, D=8, AF_THRESH=6, AE_THRESH=1)
REQ-023 Fill: reset, then write 0x01..0x08 on consecutive cycles -> o_count 1..8; o_aempty drops at count 2; o_afull rises at count 6; o_full=1 at count 8; then read 8 times -> data 0x01..0x08 in order, and o_empty=1 at end.
REQ-024 Full with simultaneous read and write: at count 8, i_wr=i_rd=1 with 0xAA -> both accepted, o_count stays 8, 0xAA is read out last; with SYNC_FIFO_ERR_EN, o_overflow stays 0.
REQ-025 Empty with simultaneous read and write: at count 0, i_wr=i_rd=1 with 0x55 -> write accepted, read rejected, o_count=1 and o_data=0x55 next cycle; o_underflow=1 with SYNC_FIFO_ERR_EN, 0 without it.
REQ-026 Wrap: 20 cycles alternating write 0x10+n / read, then 3 writes and 3 reads -> no loss or reorder across pointer wrap, o_count correct each cycle.
REQ-027 Reset mid-operation: at count 5, assert i_rst with i_wr=1 -> next cycle o_count=0, o_empty=1, o_aempty=1, o_afull=0, and sticky flags clear.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for sync_fifo: operation encoding, depth/pointer-width
// derivation and parameter legality rules.
package sync_fifo_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    localparam int W_MIN    = 1;
    localparam int W_MAX    = 64;
    localparam int LOGD_MIN = 1;
    localparam int LOGD_MAX = 12;

    function automatic int fifo_depth(input int logd);
        return 1 << logd;
    endfunction

    // One extra pointer bit separates the full case from the empty case.
    function automatic int ptr_width(input int logd);
        return logd + 1;
    endfunction

    function automatic bit params_legal(input int w, input int logd,
                                        input int af, input int ae);
        bit ok;
        ok = 1'b1;
        if (w < W_MIN || w > W_MAX) begin
            ok = 1'b0;
        end else begin
            ok = ok;
        end
        if (logd < LOGD_MIN || logd > LOGD_MAX) begin
            ok = 1'b0;
        end else begin
            ok = ok;
        end
        if (af < 1 || af > fifo_depth(logd)) begin
            ok = 1'b0;
        end else begin
            ok = ok;
        end
        if (ae < 0 || ae > fifo_depth(logd) - 1) begin
            ok = 1'b0;
        end else begin
            ok = ok;
        end
        return ok;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage for sync_fifo: one synchronous write port, one asynchronous read port.
// The array is deliberately not reset.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int W    = 8,
    parameter int LOGD = 7
) (
    input  logic            clk,
    input  logic            we,
    input  logic [LOGD-1:0] waddr,
    input  logic [W-1:0]    wdata,
    input  logic [LOGD-1:0] raddr,
    output logic [W-1:0]    rdata
);

    localparam int D = fifo_depth(LOGD);

    logic [W-1:0] mem [D];

    // Write port: only accepted writes touch the array.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered level flags.
// Define SYNC_FIFO_ERR_EN to build the sticky overflow/underflow flags.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int W         = 8,
    parameter int LOGD      = 7,
    parameter int AF_THRESH = fifo_depth(LOGD) - 2,
    parameter int AE_THRESH = 2
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic          i_wr,
    input  logic [W-1:0]  i_data,
    input  logic          i_rd,
    output logic [W-1:0]  o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_afull,
    output logic          o_aempty,
    output logic [LOGD:0] o_count,
    output logic          o_overflow,
    output logic          o_underflow
);

    localparam int PW = ptr_width(LOGD);

    localparam logic [PW-1:0] PTR_ONE = {{LOGD{1'b0}}, 1'b1};
    localparam logic [PW-1:0] CNT_D   = {1'b1, {LOGD{1'b0}}};
    localparam logic [PW-1:0] AF_T    = AF_THRESH[PW-1:0];
    localparam logic [PW-1:0] AE_T    = AE_THRESH[PW-1:0];
    localparam logic          AF_RST  = (AF_THRESH == 0) ? 1'b1 : 1'b0;

    generate
        if (!params_legal(W, LOGD, AF_THRESH, AE_THRESH)) begin : g_bad_params
            $fatal(1, "sync_fifo: illegal parameter combination");
        end
    endgenerate

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q,  count_d;
    logic          full_q,   full_d;
    logic          empty_q,  empty_d;
    logic          afull_q,  afull_d;
    logic          aempty_q, aempty_d;

    logic     rd_ok_s;
    logic     wr_ok_s;
    fifo_op_e op_s;

    // A read needs stored data; a write to a full FIFO rides on an accepted read.
    assign rd_ok_s = i_rd && !empty_q;
    assign wr_ok_s = i_wr && (!full_q || rd_ok_s);
    assign op_s    = fifo_op_e'({wr_ok_s, rd_ok_s});

    // Next pointers, count and level flags derived from the accepted operations.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        case (op_s)
            OP_WR: begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                count_d  = count_q + PTR_ONE;
            end
            OP_RD: begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                count_d  = count_q - PTR_ONE;
            end
            OP_BOTH: begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                count_d  = count_q;
            end
            default: begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                count_d  = count_q;
            end
        endcase
        full_d   = (count_d == CNT_D);
        empty_d  = (count_d == {PW{1'b0}});
        afull_d  = (count_d >= AF_T);
        aempty_d = (count_d <= AE_T);
    end

    // State registers; reset wins over any concurrent request.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {PW{1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= AF_RST;
            aempty_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q,  overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags: set on any rejected request, cleared only by reset.
    always_comb begin
        overflow_d  = overflow_q  | (i_wr && !wr_ok_s);
        underflow_d = underflow_q | (i_rd && !rd_ok_s);
    end

    // Error flag registers.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;
`else
    assign o_overflow  = 1'b0;
    assign o_underflow = 1'b0;
`endif

    sync_fifo_ram #(
        .W    (W),
        .LOGD (LOGD)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok_s),
        .waddr (wr_ptr_q[LOGD-1:0]),
        .wdata (i_data),
        .raddr (rd_ptr_q[LOGD-1:0]),
        .rdata (o_data)
    );

    assign o_full   = full_q;
    assign o_empty  = empty_q;
    assign o_afull  = afull_q;
    assign o_aempty = aempty_q;
    assign o_count  = count_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (W=8, D=8, AF=6, AE=1) against a queue model.
module tb_sync_fifo;

    localparam int W    = 8;
    localparam int LOGD = 3;
    localparam int D    = 8;
    localparam int AF   = 6;
    localparam int AE   = 1;
`ifdef SYNC_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_wr = 1'b0;
    logic         i_rd = 1'b0;
    logic [W-1:0] i_data = '0;
    logic [W-1:0] o_data;
    logic         o_full, o_empty, o_afull, o_aempty;
    logic [LOGD:0] o_count;
    logic         o_overflow, o_underflow;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mq[$];
    bit           m_ovf = 1'b0;
    bit           m_udf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo #(.W(W), .LOGD(LOGD), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_wr       (i_wr),
        .i_data     (i_data),
        .i_rd       (i_rd),
        .o_data     (o_data),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_afull    (o_afull),
        .o_aempty   (o_aempty),
        .o_count    (o_count),
        .o_overflow (o_overflow),
        .o_underflow(o_underflow)
    );

    // Drive one clock of requests and advance the reference queue by the FIFO rules.
    task automatic cyc(input bit rst, input bit wr, input bit rd, input logic [W-1:0] d);
        bit rok, wok;
        i_rst = rst; i_wr = wr; i_rd = rd; i_data = d;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            rok = rd && (mq.size() != 0);
            wok = wr && ((mq.size() < D) || rok);
            if (ERR_EN && rd && !rok) m_udf = 1'b1;
            if (ERR_EN && wr && !wok) m_ovf = 1'b1;
            if (rok) void'(mq.pop_front());
            if (wok) mq.push_back(d);
        end
        @(posedge clk);
        #1;
        i_rst = 1'b0; i_wr = 1'b0; i_rd = 1'b0;
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b1, 1'b1, 8'hFF);
        cyc(1'b1, 1'b1, 1'b1, 8'hEE);
        checks += 7;
        if (o_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", o_count); end
        if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", o_empty); end
        if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", o_full); end
        if (o_aempty !== 1'b1) begin errors++; $display("FAIL reset_aempty got %b exp 1", o_aempty); end
        if (o_afull !== 1'b0) begin errors++; $display("FAIL reset_afull got %b exp 0", o_afull); end
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", o_overflow); end
        if (o_underflow !== 1'b0) begin errors++; $display("FAIL reset_udf got %b exp 0", o_underflow); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= D; i++) begin
            cyc(1'b0, 1'b1, 1'b0, W'(i));
            checks += 5;
            if (o_count !== 4'(i)) begin errors++; $display("FAIL fill_count got %0d exp %0d", o_count, i); end
            if (o_aempty !== (i <= AE)) begin errors++; $display("FAIL fill_aempty n=%0d got %b", i, o_aempty); end
            if (o_afull !== (i >= AF)) begin errors++; $display("FAIL fill_afull n=%0d got %b", i, o_afull); end
            if (o_full !== (i == D)) begin errors++; $display("FAIL fill_full n=%0d got %b", i, o_full); end
            if (o_data !== 8'h01) begin errors++; $display("FAIL fill_head got %h exp 01", o_data); end
        end
        for (int i = 0; i < D; i++) begin
            checks++;
            if (o_data !== W'(i + 1)) begin errors++; $display("FAIL drain_data got %h exp %h", o_data, W'(i + 1)); end
            cyc(1'b0, 1'b0, 1'b1, 8'h00);
        end
        checks += 2;
        if (o_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", o_empty); end
        if (o_count !== 4'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", o_count); end
    endtask

    task automatic test_full_rw();
        logic [W-1:0] exp;
        for (int i = 0; i < D; i++) cyc(1'b0, 1'b1, 1'b0, W'(8'h30 + i));
        cyc(1'b0, 1'b1, 1'b1, 8'hAA);
        checks += 3;
        if (o_count !== 4'd8) begin errors++; $display("FAIL fullrw_count got %0d exp 8", o_count); end
        if (o_full !== 1'b1) begin errors++; $display("FAIL fullrw_full got %b exp 1", o_full); end
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL fullrw_ovf got %b exp 0", o_overflow); end
        for (int i = 0; i < D; i++) begin
            exp = (i == D - 1) ? 8'hAA : W'(8'h31 + i);
            checks++;
            if (o_data !== exp) begin errors++; $display("FAIL fullrw_data got %h exp %h", o_data, exp); end
            cyc(1'b0, 1'b0, 1'b1, 8'h00);
        end
    endtask

    task automatic test_empty_rw();
        cyc(1'b0, 1'b1, 1'b1, 8'h55);
        checks += 4;
        if (o_count !== 4'd1) begin errors++; $display("FAIL emptyrw_count got %0d exp 1", o_count); end
        if (o_data !== 8'h55) begin errors++; $display("FAIL emptyrw_data got %h exp 55", o_data); end
        if (o_empty !== 1'b0) begin errors++; $display("FAIL emptyrw_empty got %b exp 0", o_empty); end
        if (o_underflow !== ERR_EN) begin errors++; $display("FAIL emptyrw_udf got %b exp %b", o_underflow, ERR_EN); end
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_wrap();
        for (int n = 0; n < 26; n++) begin
            if (n < 20) cyc(1'b0, (n % 2) == 0, (n % 2) == 1, W'(8'h10 + n));
            else if (n < 23) cyc(1'b0, 1'b1, 1'b0, W'(8'h10 + n));
            else cyc(1'b0, 1'b0, 1'b1, 8'h00);
            checks += 2;
            if (o_count !== 4'(mq.size())) begin errors++; $display("FAIL wrap_count cyc=%0d got %0d exp %0d", n, o_count, mq.size()); end
            if (mq.size() != 0 && o_data !== mq[0]) begin errors++; $display("FAIL wrap_data cyc=%0d got %h exp %h", n, o_data, mq[0]); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            cyc(1'b0, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, W'($urandom));
            checks += 8;
            if (o_count !== 4'(mq.size())) begin errors++; $display("FAIL rnd_count got %0d exp %0d", o_count, mq.size()); end
            if (o_full !== (mq.size() == D)) begin errors++; $display("FAIL rnd_full got %b sz %0d", o_full, mq.size()); end
            if (o_empty !== (mq.size() == 0)) begin errors++; $display("FAIL rnd_empty got %b sz %0d", o_empty, mq.size()); end
            if (o_afull !== (mq.size() >= AF)) begin errors++; $display("FAIL rnd_afull got %b sz %0d", o_afull, mq.size()); end
            if (o_aempty !== (mq.size() <= AE)) begin errors++; $display("FAIL rnd_aempty got %b sz %0d", o_aempty, mq.size()); end
            if (mq.size() != 0 && o_data !== mq[0]) begin errors++; $display("FAIL rnd_data got %h exp %h", o_data, mq[0]); end
            if (o_overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf got %b exp %b", o_overflow, m_ovf); end
            if (o_underflow !== m_udf) begin errors++; $display("FAIL rnd_udf got %b exp %b", o_underflow, m_udf); end
        end
    endtask

    task automatic test_mid_reset();
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, W'(8'h60 + i));
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b0, W'(8'h70 + i));
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0, W'(8'h80 + i));
        while (mq.size() > 5) cyc(1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if (o_count !== 4'd5) begin errors++; $display("FAIL midrst_pre_count got %0d exp 5", o_count); end
        cyc(1'b1, 1'b1, 1'b0, 8'h99);
        checks += 6;
        if (o_count !== 4'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", o_count); end
        if (o_empty !== 1'b1) begin errors++; $display("FAIL midrst_empty got %b exp 1", o_empty); end
        if (o_aempty !== 1'b1) begin errors++; $display("FAIL midrst_aempty got %b exp 1", o_aempty); end
        if (o_afull !== 1'b0) begin errors++; $display("FAIL midrst_afull got %b exp 0", o_afull); end
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL midrst_ovf got %b exp 0", o_overflow); end
        if (o_underflow !== 1'b0) begin errors++; $display("FAIL midrst_udf got %b exp 0", o_underflow); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_rw();
        test_empty_rw();
        test_wrap();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
